// File: rtl/arb_pkg.sv
// Shared types and the circular first-set-bit search used by every arbiter level.
package arb_pkg;

  // Widest vector rr_pick can search; N must not exceed this.
  localparam int unsigned PICK_MAX_W = 64;
  localparam int unsigned PICK_IDX_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of vec[w-1:0], scanning upward from ptr and wrapping at w.
  function automatic pick_t rr_pick(input logic [PICK_MAX_W-1:0] vec,
                                    input logic [PICK_IDX_W-1:0] ptr,
                                    input int unsigned           w);
    pick_t       res;
    int unsigned k;
    res = '0;
    k   = 0;
    for (int unsigned i = 0; i < PICK_MAX_W; i++) begin
      if ((i < w) && !res.found) begin
        k = (32'(ptr) + i) % w;
        if (vec[k[PICK_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = k[PICK_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arbiter_tree_rr_leaf.sv
// W-wide round-robin picker with a pointer that advances past the winner on upd_i.
module rr_leaf
  import arb_pkg::*;
#(
  parameter  int unsigned W  = 2,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  vec_i,
  input  logic          upd_i,
  output logic          found_c_o,
  output logic [IW-1:0] idx_c_o
);

  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         ptr_d;
  logic [PICK_MAX_W-1:0] vec_ext;
  pick_t                 pick;

  // Combinational pick plus next pointer value.
  always_comb begin
    vec_ext          = '0;
    vec_ext[W-1:0]   = vec_i;
    pick             = rr_pick(vec_ext, PICK_IDX_W'(ptr_q), W);
    found_c_o        = pick.found;
    idx_c_o          = IW'(pick.idx);
    ptr_d            = ptr_q;
    if (upd_i && pick.found) begin
      ptr_d = IW'((32'(pick.idx) + 32'd1) % W);
    end
  end

  // Pointer register; reset gives lowest index top priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/arbiter_tree_rr.sv
// Two-level round-robin tree arbiter with transaction lock and hold timeout.
module arbiter_tree_rr
  import arb_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned LEAF     = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 preempt
);

  localparam int unsigned G         = N / LEAF;
  localparam int unsigned IDW       = $clog2(N);
  localparam int unsigned LIW       = (LEAF > 1) ? $clog2(LEAF) : 1;
  localparam int unsigned RIW       = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_e     state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic           valid_q, valid_d;
  logic           pre_q, pre_d;

  logic           owner_req_c;
  logic           expiry_c;
  logic           issue_c;
  logic [N-1:0]   masked_req_c;
  logic [G-1:0]   grp_req_c;
  logic [LIW-1:0] leaf_idx_c [G];
  logic [G-1:0]   leaf_upd_c;
  logic           root_found_c;
  logic [RIW-1:0] root_idx_c;
  logic [LIW-1:0] win_local_c;
  logic [IDW-1:0] win_id_c;
  logic [N-1:0]   win_onehot_c;

  // Owner status and request masking on hold expiry.
  always_comb begin
    owner_req_c  = req[gid_q];
    expiry_c     = (state_q == OWN) && owner_req_c && (MAX_HOLD != 0) &&
                   (hold_q == HW'(HOLD_LAST));
    masked_req_c = expiry_c ? (req & ~grant_q) : req;
  end

  for (genvar g = 0; g < G; g++) begin : g_leaf
    rr_leaf #(.W(LEAF)) u_leaf (
      .clk       (clk),
      .rst_n     (rst_n),
      .vec_i     (masked_req_c[g*LEAF +: LEAF]),
      .upd_i     (leaf_upd_c[g]),
      .found_c_o (grp_req_c[g]),
      .idx_c_o   (leaf_idx_c[g])
    );
  end

  rr_leaf #(.W(G)) u_root (
    .clk       (clk),
    .rst_n     (rst_n),
    .vec_i     (grp_req_c),
    .upd_i     (issue_c),
    .found_c_o (root_found_c),
    .idx_c_o   (root_idx_c)
  );

  // Global winner from the root choice and that group's local pick.
  always_comb begin
    win_local_c = '0;
    leaf_upd_c  = '0;
    for (int unsigned g = 0; g < G; g++) begin
      if (RIW'(g) == root_idx_c) begin
        win_local_c   = leaf_idx_c[g];
        leaf_upd_c[g] = issue_c;
      end
    end
    win_id_c     = IDW'(32'(root_idx_c) * LEAF + 32'(win_local_c));
    win_onehot_c = {{(N-1){1'b0}}, 1'b1} << win_id_c;
  end

  // Ownership FSM: next state, hold counter and next output values.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    valid_d = valid_q;
    pre_d   = 1'b0;
    issue_c = 1'b0;
    case (state_q)
      IDLE: begin
        issue_c = root_found_c;
      end
      OWN: begin
        if (!owner_req_c) begin
          if (root_found_c) begin
            issue_c = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            gid_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (expiry_c) begin
          if (root_found_c) begin
            issue_c = 1'b1;
            pre_d   = 1'b1;
          end else begin
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gid_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
    if (issue_c) begin
      state_d = OWN;
      grant_d = win_onehot_c;
      gid_d   = win_id_c;
      valid_d = 1'b1;
      hold_d  = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      grant_q <= '0;
      gid_q   <= '0;
      valid_q <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      valid_q <= valid_d;
      pre_q   <= pre_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = gid_q;
  assign preempt     = pre_q;

endmodule

// File: tb/tb_arbiter_tree_rr.sv
// Self-checking bench for arbiter_tree_rr (N=8, LEAF=2, MAX_HOLD=4).
module tb_arbiter_tree_rr;

  localparam int unsigned N        = 8;
  localparam int unsigned LEAF     = 2;
  localparam int unsigned MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_id;
  logic         preempt;

  arbiter_tree_rr #(.N(N), .LEAF(LEAF), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .preempt     (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         rst;
    logic [7:0] req;
    logic [7:0] grant;
    bit         pre;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] grant;
    bit         pre;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input string nm, input bit r, input logic [7:0] rq,
                              input logic [7:0] g, input bit p);
    vec_t v;
    v.name = nm; v.rst = r; v.req = rq; v.grant = g; v.pre = p;
    tbl.push_back(v);
  endfunction

  function automatic logic [2:0] onehot_id(input logic [7:0] g);
    logic [2:0] id;
    id = '0;
    for (int i = 0; i < 8; i++) if (g[i]) id = 3'(i);
    return id;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".grant"},       32'(grant),       32'(e.grant));
      chk({e.name, ".grant_valid"}, 32'(grant_valid), 32'(|e.grant));
      chk({e.name, ".grant_id"},    32'(grant_id),    32'(onehot_id(e.grant)));
      chk({e.name, ".preempt"},     32'(preempt),     32'(e.pre));
    end
  endtask

  task automatic apply(input string nm, input bit r, input logic [7:0] rq,
                       input logic [7:0] eg, input bit ep);
    exp_t e;
    rst_n = ~r;
    req   = rq;
    e.name = nm; e.grant = eg; e.pre = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [7:0] prev;
    rst_n = 1'b0;
    req   = '0;

    // Basic grant and release.
    add("rst0",  1, 8'h00, 8'h00, 0);
    add("basic", 0, 8'h01, 8'h01, 0);
    add("basic", 0, 8'h01, 8'h01, 0);
    add("basic", 0, 8'h01, 8'h01, 0);
    add("basic", 0, 8'h00, 8'h00, 0);
    // Root round-robin, back-to-back handover.
    add("rst1",  1, 8'h00, 8'h00, 0);
    add("root",  0, 8'h55, 8'h01, 0);
    add("root",  0, 8'h54, 8'h04, 0);
    add("root",  0, 8'h51, 8'h10, 0);
    add("root",  0, 8'h45, 8'h40, 0);
    add("root",  0, 8'h15, 8'h01, 0);
    add("root",  0, 8'h00, 8'h00, 0);
    // Leaf round-robin.
    add("rst2",  1, 8'h00, 8'h00, 0);
    add("leaf",  0, 8'h03, 8'h01, 0);
    add("leaf",  0, 8'h02, 8'h02, 0);
    add("leaf",  0, 8'h01, 8'h01, 0);
    add("leaf",  0, 8'h02, 8'h02, 0);
    add("leaf",  0, 8'h00, 8'h00, 0);
    // Hold timeout with a competitor.
    add("rst3",  1, 8'h00, 8'h00, 0);
    for (int i = 0; i < 4; i++) add("tmo", 0, 8'h03, 8'h01, 0);
    add("tmo",   0, 8'h03, 8'h02, 1);
    for (int i = 0; i < 3; i++) add("tmo", 0, 8'h03, 8'h02, 0);
    add("tmo",   0, 8'h03, 8'h01, 1);
    add("tmo",   0, 8'h03, 8'h01, 0);
    add("tmo",   0, 8'h00, 8'h00, 0);
    // Sole requester across several expiries.
    add("rst4",  1, 8'h00, 8'h00, 0);
    for (int i = 0; i < 10; i++) add("sole", 0, 8'h80, 8'h80, 0);
    add("sole",  0, 8'h00, 8'h00, 0);
    // Waiting requester drops before being granted.
    add("rst5",  1, 8'h00, 8'h00, 0);
    add("drop",  0, 8'h03, 8'h01, 0);
    add("drop",  0, 8'h01, 8'h01, 0);
    add("drop",  0, 8'h00, 8'h00, 0);
    // Reset in the middle of ownership.
    add("rst6",  1, 8'h00, 8'h00, 0);
    add("midrst", 0, 8'h20, 8'h20, 0);
    add("midrst", 0, 8'h20, 8'h20, 0);
    add("midrst", 1, 8'hFF, 8'h00, 0);
    add("midrst", 0, 8'hFF, 8'h01, 0);
    add("midrst", 0, 8'hFF, 8'h01, 0);
    add("rst7",  1, 8'h00, 8'h00, 0);

    foreach (tbl[i]) apply($sformatf("%s[%0d]", tbl[i].name, i),
                           tbl[i].rst, tbl[i].req, tbl[i].grant, tbl[i].pre);

    // Random traffic: structural properties of the grant.
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      prev = 8'($urandom);
      if ((c % 7) == 0) prev = '0;
      req = prev;
      @(posedge clk);
      #1;
      chk($sformatf("rand[%0d].onehot", c), 32'($onehot0(grant)), 32'd1);
      chk($sformatf("rand[%0d].requested", c), 32'(grant & ~prev), 32'd0);
      if (grant_valid) chk($sformatf("rand[%0d].id", c), 32'(grant[grant_id]), 32'd1);
      else             chk($sformatf("rand[%0d].idle_id", c), 32'(grant_id), 32'd0);
      if (prev == 8'h00) chk($sformatf("rand[%0d].release", c), 32'(grant), 32'd0);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
